// File: rtl/bullet_wall_detect.sv
// bullet_wall_detect: per-frame bullet-vs-wall probe over a shared wall-map read port.
// Define BULLET_CORNER_PROBE_EN to add a diagonal probe when both axis probes are clear.
module bullet_wall_detect #(
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479,
    parameter int CELL_SHIFT = 3,
    parameter int MAP_COLS   = 80
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        is_bullet_active,
    input  logic [9:0]  BulletX,
    input  logic [9:0]  BulletY,
    input  logic [9:0]  BulletXStep,
    input  logic [9:0]  BulletYStep,
    output logic        map_req,
    output logic [12:0] map_addr,
    input  logic        map_gnt,
    input  logic        map_data,
    output logic        isWallTop,
    output logic        isWallBottom,
    output logic        isWallLeft,
    output logic        isWallRight,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE, PROBE_X, WAIT_X, PROBE_Y, WAIT_Y, DONE
`ifdef BULLET_CORNER_PROBE_EN
        , PROBE_C, WAIT_C
`endif
    } state_t;
    localparam logic [9:0] XM = 10'(X_MAX);
    localparam logic [9:0] YM = 10'(Y_MAX);
    state_t      r_state, w_next;
    logic        r_sync1, r_sync2, r_hist;
    logic [9:0]  r_x, r_y, r_dx, r_dy;
    logic        r_st, r_sb, r_sl, r_sr;
    logic        r_top, r_bot, r_left, r_right;
    logic        w_edge, w_cst, w_use_dx, w_use_dy, w_probe;
    logic        w_zero, w_oob, w_need, w_hit;
    logic [10:0] w_px, w_py;
    logic [9:0]  w_col, w_row;
    logic [12:0] w_addr;

    assign w_edge = r_sync2 & ~r_hist;
    assign busy   = r_state != IDLE;
    assign {isWallTop, isWallBottom, isWallLeft, isWallRight} = {r_top, r_bot, r_left, r_right};
`ifdef BULLET_CORNER_PROBE_EN
    assign w_cst  = (r_state == PROBE_C) || (r_state == WAIT_C);
    assign w_probe = (r_state == PROBE_X) || (r_state == PROBE_Y) || (r_state == PROBE_C);
`else
    assign w_cst  = 1'b0;
    assign w_probe = (r_state == PROBE_X) || (r_state == PROBE_Y);
`endif
    assign w_use_dx = (r_state == PROBE_X) || (r_state == WAIT_X) || w_cst;
    assign w_use_dy = (r_state == PROBE_Y) || (r_state == WAIT_Y) || w_cst;

    // Probe point is a function of the state, so it stays stable across a stalled request.
    assign w_px   = {1'b0, r_x} + (w_use_dx ? {r_dx[9], r_dx} : 11'd0);
    assign w_py   = {1'b0, r_y} + (w_use_dy ? {r_dy[9], r_dy} : 11'd0);
    assign w_zero = (w_use_dx && r_dx == 10'd0) || (w_use_dy && r_dy == 10'd0);
    assign w_oob  = w_px[10] | w_py[10] | (w_px[9:0] > XM) | (w_py[9:0] > YM);
    assign w_need = ~w_zero & ~w_oob;
    assign w_hit  = ~w_zero & (w_oob | map_data);
    assign w_col  = w_px[9:0] >> CELL_SHIFT;
    assign w_row  = w_py[9:0] >> CELL_SHIFT;

    always_comb begin
        w_addr = 13'(w_col);
        for (int i = 0; i < 13; i++)
            w_addr = w_addr + (MAP_COLS[i] ? 13'(w_row) << i : 13'd0);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        map_req  = w_probe & w_need;
        map_addr = (w_probe & w_need) ? w_addr : 13'd0;
        case (r_state)
            PROBE_X: w_next = (map_gnt || !w_need) ? WAIT_X : PROBE_X;
            WAIT_X:  w_next = PROBE_Y;
            PROBE_Y: w_next = (map_gnt || !w_need) ? WAIT_Y : PROBE_Y;
`ifdef BULLET_CORNER_PROBE_EN
            WAIT_Y:  w_next = (~(r_sl | r_sr) & ~w_hit & (r_dx != 10'd0) & (r_dy != 10'd0)) ? PROBE_C : DONE;
            PROBE_C: w_next = (map_gnt || !w_need) ? WAIT_C : PROBE_C;
            WAIT_C:  w_next = DONE;
`else
            WAIT_Y:  w_next = DONE;
`endif
            default: w_next = IDLE;
        endcase
        if (w_edge) w_next = is_bullet_active ? PROBE_X : IDLE;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            {r_sync1, r_sync2, r_hist} <= '0;
            {r_x, r_y, r_dx, r_dy} <= '0;
            {r_st, r_sb, r_sl, r_sr} <= '0;
            {r_top, r_bot, r_left, r_right} <= '0;
        end else begin
            {r_hist, r_sync2, r_sync1} <= {r_sync2, r_sync1, frame_clk};
            if (w_edge) begin
                {r_st, r_sb, r_sl, r_sr} <= '0;
                if (is_bullet_active) {r_x, r_y, r_dx, r_dy} <= {BulletX, BulletY, BulletXStep, BulletYStep};
                else {r_top, r_bot, r_left, r_right} <= '0;
            end else if (w_hit && r_state == WAIT_X) begin
                {r_sl, r_sr} <= {r_dx[9], ~r_dx[9]};
            end else if (w_hit && r_state == WAIT_Y) begin
                {r_st, r_sb} <= {r_dy[9], ~r_dy[9]};
`ifdef BULLET_CORNER_PROBE_EN
            end else if (w_hit && r_state == WAIT_C) begin
                {r_st, r_sb, r_sl, r_sr} <= {r_dy[9], ~r_dy[9], r_dx[9], ~r_dx[9]};
`endif
            end else if (r_state == DONE) begin
                {r_top, r_bot, r_left, r_right} <= {r_st, r_sb, r_sl, r_sr};
            end
        end
    end
endmodule

// File: doc/bullet_wall_detect.md
BULLET_WALL_DETECT -- requirements
Module: bullet_wall_detect

Interface
REQ-001 Parameter X_MAX, 639: rightmost legal pixel column.
REQ-002 Parameter Y_MAX, 479: bottom legal pixel row.
REQ-003 Parameter CELL_SHIFT, 3: log2 of the square wall-map cell size in pixels.
REQ-004 Parameter MAP_COLS, 80: wall-map cells per row.
REQ-005 Clk  in  1  system clock; the only clock; all logic is on its rising edge.
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 frame_clk  in  1  frame strobe, sampled as data in the Clk domain.
REQ-008 is_bullet_active  in  1  bullet in flight.
REQ-009 BulletX, BulletY  in  10  bullet pixel position, unsigned.
REQ-010 BulletXStep, BulletYStep  in  10  per-frame motion, two's complement; +Y is downward.
REQ-011 map_req  out  1  wall-map read request.
REQ-012 map_addr  out  13  cell index.
REQ-013 map_gnt  in  1  grant for map_req.
REQ-014 map_data  in  1  1 = wall, valid the cycle after a granted request.
REQ-015 isWallTop, isWallBottom, isWallLeft, isWallRight  out  1  collision flags for the bullet.
REQ-016 busy  out  1  probe sequence in progress.

Function
REQ-017 The block SHALL detect a frame edge when frame_clk is 1 on the current Clk and was 0 on the previous Clk, using a two-flop synchroniser followed by one history flop.
REQ-018 On a frame edge, the block SHALL latch BulletX, BulletY, BulletXStep and BulletYStep and leave IDLE.
- If is_bullet_active is 0, it SHALL instead clear all four flags and stay in IDLE.
REQ-019 FSM states: IDLE, PROBE_X, WAIT_X, PROBE_Y, WAIT_Y, [PROBE_C, WAIT_C], DONE. DONE SHALL return to IDLE after one cycle.
REQ-020 The X probe point is (X+dx, Y). The Y probe point is (X, Y+dy). Both SHALL be computed as 11-bit signed values.
REQ-021 A probe point with a coordinate <0, x>X_MAX or y>Y_MAX SHALL count as a wall.
- No map request is issued for it.
- The FSM passes through the WAIT state in one cycle.
REQ-022 A probe with a zero step component SHALL count as clear, with no map request.
REQ-023 map_addr SHALL equal (y>>CELL_SHIFT)*MAP_COLS + (x>>CELL_SHIFT), built with shifts and adds only.
REQ-024 In a PROBE state, map_req SHALL be held high with map_addr stable until a cycle with map_gnt=1.
- map_data SHALL be sampled in the following cycle.
- map_req SHALL fall in the cycle after the grant.
REQ-025 X probe wall with dx>0 sets isWallRight; with dx<0 sets isWallLeft. Y probe wall with dy>0 sets isWallBottom; with dy<0 sets isWallTop.
REQ-026 Flags SHALL be computed into shadow registers and copied to the outputs together in DONE.
- Outputs SHALL hold until the next DONE or an inactive-bullet clear.
- At most one X flag and at most one Y flag SHALL be set.
REQ-027 A frame edge arriving while busy=1 SHALL abort the sequence and restart with a freshly latched position. Outputs SHALL stay unchanged until the restarted sequence reaches DONE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Latency: with map_gnt tied high, DONE SHALL be reached within 6 Clk cycles of the edge-detect cycle (8 with the corner probe).

Reset
REQ-030 While Reset_n=0: all flags 0, map_req 0, map_addr 0, busy 0, FSM in IDLE, synchroniser and shadow registers 0.
REQ-031 A reset asserted mid-sequence SHALL discard the sequence, leave no outstanding request after release, and require a new frame edge to start.

Configuration
REQ-032 With BULLET_CORNER_PROBE_EN defined: if the X and Y probes are both clear and both steps are non-zero, the block SHALL probe (X+dx, Y+dy) in PROBE_C/WAIT_C. A wall there SHALL set both the X flag and the Y flag selected by the step signs.
REQ-033 Without BULLET_CORNER_PROBE_EN: PROBE_C and WAIT_C do not exist and a diagonal-only wall sets no flag.

Verification
REQ-034 X=100,Y=100, dx=+4, dy=0, cell (13,12) wall, map_gnt=1 -> map_addr=973; isWallRight=1 and all other flags 0 within 6 cycles.
REQ-035 X=2,Y=50, dx=-4, dy=-4, map all clear -> no request for the X probe; isWallLeft=1, isWallTop=0.
REQ-036 Y=478, dy=+3, dx=0 -> isWallBottom=1 with zero map requests.
REQ-037 map_gnt held 0 for 5 cycles -> map_req and map_addr stable throughout; result correct after the grant.
REQ-038 Frame edge, then Reset_n low in WAIT_X, then released -> all outputs 0, FSM idle; the next edge yields correct flags.
REQ-039 With BULLET_CORNER_PROBE_EN: X=100,Y=100, dx=+8, dy=+8, only cell (13,13) wall -> isWallRight=1, isWallBottom=1. Without the macro -> no flags.
